// File: rtl/dot_product_accumulator_pkg.sv
// ============================================================================
// Module      : dot_product_pkg
// Description : Shared types and sizing helpers for the dot-product MAC stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dot_product_pkg;

    typedef enum logic [1:0] {
        eAccept = 2'd0,
        eDrain  = 2'd1,
        eDone   = 2'd2
    } state_e;

    // Sum width that can hold `terms` full-scale products without wrapping
    function automatic int acc_width_f(input int width, input int terms);
        return 2 * width + $clog2(terms);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dot_product_accumulator_if.sv
// ============================================================================
// Module      : dot_product_accumulator_if
// Description : Operand-in / sum-out valid-ready bundle for the MAC stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dot_product_accumulator_if
    import dot_product_pkg::*;
#(
    parameter int width_p     = 16,
    parameter int terms_p     = 4,
    parameter int acc_width_p = acc_width_f(width_p, terms_p)
);
    logic                   valid_i;
    logic                   ready_o;
    logic [width_p-1:0]     a_i;
    logic [width_p-1:0]     b_i;
    logic                   valid_o;
    logic                   ready_i;
    logic [acc_width_p-1:0] sum_o;

    modport master (
        output valid_i, a_i, b_i, ready_i,
        input  ready_o, valid_o, sum_o
    );

    modport slave (
        input  valid_i, a_i, b_i, ready_i,
        output ready_o, valid_o, sum_o
    );
endinterface

`default_nettype wire

// File: rtl/dot_product_accumulator_multiplier.sv
// ============================================================================
// Module      : multiplier
// Description : Combinational unsigned multiplier, full-width product.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplier #(
    parameter int width_lp = 16
) (
    input  logic [width_lp-1:0]   a_i,
    input  logic [width_lp-1:0]   b_i,
    output logic [2*width_lp-1:0] c_o
);
    assign c_o = {{width_lp{1'b0}}, a_i} * {{width_lp{1'b0}}, b_i};
endmodule

`default_nettype wire

// File: rtl/dot_product_accumulator.sv
// ============================================================================
// Module      : dot_product_accumulator
// Description : Pipelined MAC: registers each product, sums terms_p of them,
//               and offers the result over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dot_product_accumulator
    import dot_product_pkg::*;
#(
    parameter int width_p     = 16,
    parameter int terms_p     = 4,
    parameter int acc_width_p = acc_width_f(width_p, terms_p)
) (
    input  wire logic               clk_i,
    input  wire logic               reset_i,
    dot_product_accumulator_if.slave bus
);
    localparam int cnt_width_lp = (terms_p > 1) ? $clog2(terms_p) : 1;
    localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(terms_p - 1);

    state_e                   state_r;
    state_e                   state_n;
    logic [2*width_p-1:0]     mult_c;
    logic [2*width_p-1:0]     product_r;
    logic                     pv_r;
    logic [acc_width_p-1:0]   acc_r;
    logic [cnt_width_lp-1:0]  accept_cnt;
    logic [cnt_width_lp-1:0]  add_cnt;
    logic                     in_hs;
    logic                     out_hs;

    multiplier #(
        .width_lp (width_p)
    ) u_multiplier (
        .a_i (bus.a_i),
        .b_i (bus.b_i),
        .c_o (mult_c)
    );

    // Handshake strobes use only the state-decoded ready/valid
    assign bus.ready_o = (state_r == eAccept);
    assign bus.valid_o = (state_r == eDone);
    assign bus.sum_o   = acc_r;
    assign in_hs       = bus.valid_i && bus.ready_o;
    assign out_hs      = bus.valid_o && bus.ready_i;

    always_comb begin
        state_n = state_r;
        case (state_r)
            eAccept: if (in_hs && accept_cnt == last_cnt_lp) state_n = eDrain;
            eDrain:  if (pv_r && add_cnt == last_cnt_lp)     state_n = eDone;
            eDone:   if (out_hs)                             state_n = eAccept;
            default: state_n = eAccept;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= eAccept;
            product_r  <= '0;
            pv_r       <= 1'b0;
            acc_r      <= '0;
            accept_cnt <= '0;
            add_cnt    <= '0;
        end else begin
            state_r <= state_n;
            pv_r    <= in_hs;
            if (in_hs) begin
                product_r <= mult_c;
            end

            // Counters saturate at terms_p-1; the output handshake rearms them
            if (out_hs) begin
                acc_r      <= '0;
                accept_cnt <= '0;
                add_cnt    <= '0;
            end else begin
                if (pv_r) begin
                    acc_r <= acc_r + acc_width_p'(product_r);
                    if (add_cnt != last_cnt_lp) begin
                        add_cnt <= add_cnt + 1'b1;
                    end
                end
                if (in_hs && accept_cnt != last_cnt_lp) begin
                    accept_cnt <= accept_cnt + 1'b1;
                end
            end
        end
    end
endmodule

`default_nettype wire
